commit_opnds: RTL and testbench



---
 rtl/commit_opnds.sv | 250 +++++++++++++++++++++++++
 tb/tb_commit_opnds.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_opnds.sv
// -----------------------------------------------------------------------------
// commit_opnds
//
// Write-side counterpart of operand decode. Accepts one commit bundle (two
// decoded destinations, their result values and effective addresses, plus two
// memory-write hints). It then walks the destinations one per cycle:
//   - register destinations drive a single-cycle register-file write;
//   - memory destinations are matched against the write hints.
// Once both destinations have been processed, the fault status is presented
// and held until the consumer accepts it.
//
// Sequence: IDLE -> D0 -> D1 -> DONE -> IDLE.
// Accept in cycle N; the dest0 write is in N+1, the dest1 write is in N+2,
// and out_valid first goes high in N+3.
//
// Ports
//   clk, rst_n                clock, asynchronous active-low reset
//   in_valid / in_ready       bundle handshake (in_ready high only in IDLE)
//   reg_1byte                 8-bit operand size
//   prefix_operand_16bit      16-bit operand size (reg_1byte has priority)
//   destN_kind                bit0 = register destination, bit1 = memory
//                             destination, 2'b00 = none; 2'b11 acts as register
//   destN_sel                 register selector, bits [2:0] only
//   resN / addrN              result value / effective address per destination
//   hintN_is_write/_address/_data   memory-write hints to check against
//   reg_we/reg_wsel/reg_wmask/reg_wdata   register-file write port
//   out_valid / out_ready     completion handshake
//   fault / fault_code        [0] dest0 mem mismatch, [1] dest1 mem mismatch,
//                             [2] write hint left unconsumed
// -----------------------------------------------------------------------------
module commit_opnds (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        reg_1byte,
   input  logic        prefix_operand_16bit,
   input  logic [1:0]  dest0_kind,
   input  logic [1:0]  dest1_kind,
   input  logic [31:0] dest0_sel,
   input  logic [31:0] dest1_sel,
   input  logic [31:0] res0,
   input  logic [31:0] res1,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   input  logic        hint1_is_write,
   input  logic        hint2_is_write,
   input  logic [31:0] hint1_address,
   input  logic [31:0] hint2_address,
   input  logic [31:0] hint1_data,
   input  logic [31:0] hint2_data,
   output logic        reg_we,
   output logic [2:0]  reg_wsel,
   output logic [3:0]  reg_wmask,
   output logic [31:0] reg_wdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        fault,
   output logic [2:0]  fault_code
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_D0   = 2'd1,
      S_D1   = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t state_reg, state_next;

   // Captured bundle. Index 0/1 is the first/second destination or hint.
   logic             size8_reg;
   logic             size16_reg;
   logic [1:0][1:0]  kind_reg;
   logic [1:0][2:0]  sel_reg;
   logic [1:0][31:0] res_reg;
   logic [1:0][31:0] addr_reg;
   logic [1:0]       hint_we_reg;
   logic [1:0][31:0] hint_addr_reg;
   logic [1:0][31:0] hint_data_reg;
   logic [1:0]       consumed_reg, consumed_next;
   logic [2:0]       fault_code_reg, fault_code_next;

   logic        accept;
   logic        active;
   logic        cur;          // 0 while in D0, 1 while in D1
   logic [1:0]  cur_kind;
   logic [2:0]  cur_sel;
   logic [31:0] cur_res;
   logic [31:0] cur_addr;
   logic        dest_is_reg;
   logic        dest_is_mem;
   logic [3:0]  size_mask;
   logic [31:0] lane_bits;
   logic [1:0]  hint_hit;
   logic [1:0]  hint_take;

   assign accept = in_valid && (state_reg == S_IDLE);
   assign active = (state_reg == S_D0) || (state_reg == S_D1);
   assign cur    = (state_reg == S_D1);

   assign cur_kind = kind_reg[cur];
   assign cur_sel  = sel_reg[cur];
   assign cur_res  = res_reg[cur];
   assign cur_addr = addr_reg[cur];

   // A kind with both bits set is treated as a register destination only.
   assign dest_is_reg = active && cur_kind[0];
   assign dest_is_mem = active && cur_kind[1] && !cur_kind[0];

   // Operand-size lane mask; the 8-bit size takes priority over the 16-bit prefix.
   always_comb begin
      size_mask = 4'b1111;
      if (size8_reg) begin
         size_mask = 4'b0001;
      end else if (size16_reg) begin
         size_mask = 4'b0011;
      end
   end

   // Expand the byte-lane mask to a bit mask.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign lane_bits[gi*8 +: 8] = {8{size_mask[gi]}};
      end
   endgenerate

   // Hint comparison. Only the bytes covered by the operand size take part in
   // the data comparison.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_hint
         assign hint_hit[gi] = hint_we_reg[gi] && !consumed_reg[gi] &&
                               (hint_addr_reg[gi] == cur_addr) &&
                               (((hint_data_reg[gi] ^ cur_res) & lane_bits) == 32'd0);
      end
   endgenerate

   // The first hint has priority over the second; at most one hint is
   // consumed per destination.
   always_comb begin
      hint_take = 2'b00;
      if (hint_hit[0]) begin
         hint_take = 2'b01;
      end else if (hint_hit[1]) begin
         hint_take = 2'b10;
      end
   end

   always_comb begin
      consumed_next   = consumed_reg;
      fault_code_next = fault_code_reg;
      if (dest_is_mem) begin
         consumed_next = consumed_reg | hint_take;
         if (hint_take == 2'b00) begin
            if (cur) begin
               fault_code_next[1] = 1'b1;
            end else begin
               fault_code_next[0] = 1'b1;
            end
         end
      end
      // The last destination has been processed; any write hint still
      // unconsumed means the execute stage issued a write the bundle never made.
      if (state_reg == S_D1) begin
         fault_code_next[2] = |(hint_we_reg & ~consumed_next);
      end
   end

   // Register-file write port.
   always_comb begin
      reg_we    = 1'b0;
      reg_wsel  = 3'd0;
      reg_wmask = 4'd0;
      reg_wdata = 32'd0;
      if (dest_is_reg) begin
         reg_we = 1'b1;
         if (size8_reg && cur_sel[2]) begin
            // AH/CH/DH/BH live in byte 1 of EAX/ECX/EDX/EBX.
            reg_wsel  = {1'b0, cur_sel[1:0]};
            reg_wmask = 4'b0010;
            reg_wdata = {16'd0, cur_res[7:0], 8'd0};
         end else begin
            reg_wsel  = cur_sel;
            reg_wmask = size_mask;
            reg_wdata = cur_res & lane_bits;
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: if (in_valid) state_next = S_D0;
         S_D0:   state_next = S_D1;
         S_D1:   state_next = S_DONE;
         S_DONE: if (out_ready) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= S_IDLE;
         size8_reg      <= 1'b0;
         size16_reg     <= 1'b0;
         kind_reg       <= '0;
         sel_reg        <= '0;
         res_reg        <= '0;
         addr_reg       <= '0;
         hint_we_reg    <= '0;
         hint_addr_reg  <= '0;
         hint_data_reg  <= '0;
         consumed_reg   <= '0;
         fault_code_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            size8_reg        <= reg_1byte;
            size16_reg       <= prefix_operand_16bit;
            kind_reg[0]      <= dest0_kind;
            kind_reg[1]      <= dest1_kind;
            sel_reg[0]       <= dest0_sel[2:0];
            sel_reg[1]       <= dest1_sel[2:0];
            res_reg[0]       <= res0;
            res_reg[1]       <= res1;
            addr_reg[0]      <= addr0;
            addr_reg[1]      <= addr1;
            hint_we_reg      <= {hint2_is_write, hint1_is_write};
            hint_addr_reg[0] <= hint1_address;
            hint_addr_reg[1] <= hint2_address;
            hint_data_reg[0] <= hint1_data;
            hint_data_reg[1] <= hint2_data;
            consumed_reg     <= '0;
            fault_code_reg   <= '0;
         end else if (active) begin
            consumed_reg   <= consumed_next;
            fault_code_reg <= fault_code_next;
         end
      end
   end

   // Status outputs are decoded from the registered state, so they stay put
   // for as long as DONE is held by out_ready=0.
   assign in_ready   = (state_reg == S_IDLE);
   assign out_valid  = (state_reg == S_DONE);
   assign fault_code = out_valid ? fault_code_reg : 3'd0;
   assign fault      = |fault_code;

endmodule

// File: tb/tb_commit_opnds.sv
// -----------------------------------------------------------------------------
// tb_commit_opnds: table-driven vectors, hand-written handshake/reset
// sequences, and random bundles compared with a behavioural model.
// Destination kind encoding: bit0 = register, bit1 = memory.
// -----------------------------------------------------------------------------
module tb_commit_opnds;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        reg_1byte;
   logic        prefix_operand_16bit;
   logic [1:0]  dest0_kind, dest1_kind;
   logic [31:0] dest0_sel, dest1_sel;
   logic [31:0] res0, res1, addr0, addr1;
   logic        hint1_is_write, hint2_is_write;
   logic [31:0] hint1_address, hint2_address, hint1_data, hint2_data;
   logic        reg_we;
   logic [2:0]  reg_wsel;
   logic [3:0]  reg_wmask;
   logic [31:0] reg_wdata;
   logic        out_valid;
   logic        out_ready;
   logic        fault;
   logic [2:0]  fault_code;

   commit_opnds dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .reg_1byte(reg_1byte), .prefix_operand_16bit(prefix_operand_16bit),
      .dest0_kind(dest0_kind), .dest1_kind(dest1_kind),
      .dest0_sel(dest0_sel), .dest1_sel(dest1_sel),
      .res0(res0), .res1(res1), .addr0(addr0), .addr1(addr1),
      .hint1_is_write(hint1_is_write), .hint2_is_write(hint2_is_write),
      .hint1_address(hint1_address), .hint2_address(hint2_address),
      .hint1_data(hint1_data), .hint2_data(hint2_data),
      .reg_we(reg_we), .reg_wsel(reg_wsel), .reg_wmask(reg_wmask),
      .reg_wdata(reg_wdata), .out_valid(out_valid), .out_ready(out_ready),
      .fault(fault), .fault_code(fault_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit        r1b;
      bit        p16;
      bit [1:0]  k0;
      bit [31:0] s0, r0, a0;
      bit [1:0]  k1;
      bit [31:0] s1, r1, a1;
      bit        h1w;
      bit [31:0] h1a, h1d;
      bit        h2w;
      bit [31:0] h2a, h2d;
      bit        e_we0;
      bit [2:0]  e_sel0;
      bit [3:0]  e_mask0;
      bit [31:0] e_data0;
      bit        e_we1;
      bit [2:0]  e_sel1;
      bit [3:0]  e_mask1;
      bit [31:0] e_data1;
      bit [2:0]  e_code;
   } vec_t;

   int checks;
   int failures;

   // Observations from the last run
   logic        o_we   [2];
   logic [2:0]  o_sel  [2];
   logic [3:0]  o_mask [2];
   logic [31:0] o_data [2];
   logic        o_we_late;
   int          o_lat;
   logic        o_fault;
   logic [2:0]  o_code;
   logic        o_ready_after;

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s vec=%0d actual=0x%08h required=0x%08h", nm, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      reg_1byte = v.r1b; prefix_operand_16bit = v.p16;
      dest0_kind = v.k0; dest0_sel = v.s0; res0 = v.r0; addr0 = v.a0;
      dest1_kind = v.k1; dest1_sel = v.s1; res1 = v.r1; addr1 = v.a1;
      hint1_is_write = v.h1w; hint1_address = v.h1a; hint1_data = v.h1d;
      hint2_is_write = v.h2w; hint2_address = v.h2a; hint2_data = v.h2d;
   endtask

   task automatic scramble_inputs();
      dest0_kind = 2'($urandom); dest1_kind = 2'($urandom);
      dest0_sel = $urandom; dest1_sel = $urandom;
      res0 = $urandom; res1 = $urandom; addr0 = $urandom; addr1 = $urandom;
      hint1_is_write = 1'($urandom); hint2_is_write = 1'($urandom);
      hint1_address = $urandom; hint1_data = $urandom;
      hint2_address = $urandom; hint2_data = $urandom;
      reg_1byte = 1'($urandom); prefix_operand_16bit = 1'($urandom);
   endtask

   // Apply one bundle and record what the DUT does over the following cycles.
   task automatic run(input vec_t v);
      @(negedge clk);
      drive(v);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      scramble_inputs();   // must have no effect after capture
      o_lat = 0; o_we_late = 1'b0; o_fault = 1'b0; o_code = 3'd0;
      for (int c = 1; c <= 8; c++) begin
         if (c > 1) @(negedge clk);
         if (c <= 2) begin
            o_we[c-1] = reg_we; o_sel[c-1] = reg_wsel;
            o_mask[c-1] = reg_wmask; o_data[c-1] = reg_wdata;
         end else begin
            o_we_late = o_we_late | reg_we;
         end
         if (out_valid) begin
            o_lat = c; o_fault = fault; o_code = fault_code;
            break;
         end
      end
      @(negedge clk);
      o_ready_after = in_ready;
   endtask

   task automatic verify(input vec_t v, input int idx);
      chk("we_d0", idx, 32'(o_we[0]), 32'(v.e_we0));
      if (v.e_we0) begin
         chk("wsel_d0", idx, 32'(o_sel[0]), 32'(v.e_sel0));
         chk("wmask_d0", idx, 32'(o_mask[0]), 32'(v.e_mask0));
         chk("wdata_d0", idx, o_data[0], v.e_data0);
      end
      chk("we_d1", idx, 32'(o_we[1]), 32'(v.e_we1));
      if (v.e_we1) begin
         chk("wsel_d1", idx, 32'(o_sel[1]), 32'(v.e_sel1));
         chk("wmask_d1", idx, 32'(o_mask[1]), 32'(v.e_mask1));
         chk("wdata_d1", idx, o_data[1], v.e_data1);
      end
      chk("we_late", idx, 32'(o_we_late), 32'd0);
      chk("latency", idx, o_lat, 32'd3);
      chk("fault_code", idx, 32'(o_code), 32'(v.e_code));
      chk("fault", idx, 32'(o_fault), 32'(v.e_code != 3'd0));
      chk("in_ready_after", idx, 32'(o_ready_after), 32'd1);
   endtask

   // Behavioural model: derives the expected writes and fault code directly
   // from the commit rules.
   function automatic vec_t model(input vec_t v);
      vec_t      m = v;
      int        nbytes;
      bit [31:0] keep;
      bit        hw   [2];
      bit [31:0] ha   [2];
      bit [31:0] hd   [2];
      bit        used [2];
      bit [1:0]  kind [2];
      bit [31:0] sel  [2];
      bit [31:0] res  [2];
      bit [31:0] adr  [2];
      bit        we   [2];
      bit [2:0]  wsel [2];
      bit [3:0]  wmask[2];
      bit [31:0] wdata[2];
      bit [2:0]  code = 3'd0;
      nbytes = v.r1b ? 1 : (v.p16 ? 2 : 4);
      keep   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
      hw[0] = v.h1w; ha[0] = v.h1a; hd[0] = v.h1d;
      hw[1] = v.h2w; ha[1] = v.h2a; hd[1] = v.h2d;
      used[0] = 1'b0; used[1] = 1'b0;
      kind[0] = v.k0; sel[0] = v.s0; res[0] = v.r0; adr[0] = v.a0;
      kind[1] = v.k1; sel[1] = v.s1; res[1] = v.r1; adr[1] = v.a1;
      for (int i = 0; i < 2; i++) begin
         we[i] = 1'b0; wsel[i] = 3'd0; wmask[i] = 4'd0; wdata[i] = 32'd0;
         if (kind[i][0]) begin
            int s = int'(sel[i] % 8);
            we[i] = 1'b1;
            if (nbytes == 1 && s >= 4) begin
               wsel[i]  = 3'(s - 4);
               wmask[i] = 4'b0010;
               wdata[i] = (res[i] & 32'hFF) << 8;
            end else begin
               wsel[i]  = 3'(s);
               wmask[i] = 4'((1 << nbytes) - 1);
               wdata[i] = res[i] & keep;
            end
         end else if (kind[i][1]) begin
            bit found = 1'b0;
            for (int h = 0; h < 2; h++) begin
               if (!found && hw[h] && !used[h] && ha[h] == adr[i] &&
                   (hd[h] & keep) == (res[i] & keep)) begin
                  used[h] = 1'b1;
                  found   = 1'b1;
               end
            end
            if (!found) code[i] = 1'b1;
         end
      end
      for (int h = 0; h < 2; h++) if (hw[h] && !used[h]) code[2] = 1'b1;
      m.e_we0 = we[0]; m.e_sel0 = wsel[0]; m.e_mask0 = wmask[0]; m.e_data0 = wdata[0];
      m.e_we1 = we[1]; m.e_sel1 = wsel[1]; m.e_mask1 = wmask[1]; m.e_data1 = wdata[1];
      m.e_code = code;
      return m;
   endfunction

   vec_t tbl [12];

   initial begin
      vec_t v;
      checks = 0;
      failures = 0;

      // Fields: r1b,p16, k0,s0,r0,a0, k1,s1,r1,a1, h1w,h1a,h1d, h2w,h2a,h2d,
      //         e_we0,e_sel0,e_mask0,e_data0, e_we1,e_sel1,e_mask1,e_data1, e_code
      tbl[0]  = '{0,0, 2'b01,3,32'hDEADBEEF,0, 2'b00,0,0,0, 0,0,0, 0,0,0,
                  1,3,4'hF,32'hDEADBEEF, 0,0,0,0, 3'b000};
      tbl[1]  = '{1,0, 2'b01,5,32'h000000A5,0, 2'b00,0,0,0, 0,0,0, 0,0,0,
                  1,1,4'h2,32'h0000A500, 0,0,0,0, 3'b000};
      tbl[2]  = '{1,0, 2'b01,2,32'h00001234,0, 2'b01,7,32'h000000C3,0, 0,0,0, 0,0,0,
                  1,2,4'h1,32'h00000034, 1,3,4'h2,32'h0000C300, 3'b000};
      tbl[3]  = '{0,1, 2'b01,6,32'hCAFEBABE,0, 2'b01,32'hFFFFFFF6,32'h11112222,0, 0,0,0, 0,0,0,
                  1,6,4'h3,32'h0000BABE, 1,6,4'h3,32'h00002222, 3'b000};
      tbl[4]  = '{0,0, 2'b00,0,0,0, 2'b10,0,32'h12345678,32'h1000,
                  0,32'h1000,32'h12345678, 1,32'h1000,32'h12345678,
                  0,0,0,0, 0,0,0,0, 3'b000};
      // A mismatching second hint is also a write hint left unconsumed.
      tbl[5]  = '{0,0, 2'b00,0,0,0, 2'b10,0,32'h12345678,32'h1000,
                  0,32'h1000,32'h12345678, 1,32'h1000,32'h12345679,
                  0,0,0,0, 0,0,0,0, 3'b110};
      tbl[6]  = '{0,0, 2'b01,0,32'h0BADF00D,0, 2'b00,0,0,0,
                  1,32'h2000,0, 0,0,0,
                  1,0,4'hF,32'h0BADF00D, 0,0,0,0, 3'b100};
      tbl[7]  = '{1,0, 2'b10,0,32'h00000055,32'h40, 2'b10,0,32'h000000AA,32'h40,
                  1,32'h40,32'hFFFFFF55, 1,32'h40,32'h123456AA,
                  0,0,0,0, 0,0,0,0, 3'b000};
      tbl[8]  = '{0,0, 2'b10,0,32'h0000AAAA,32'h40, 2'b10,0,32'h0000BBBB,32'h40,
                  1,32'h40,32'h0000AAAA, 0,0,0,
                  0,0,0,0, 0,0,0,0, 3'b010};
      tbl[9]  = '{0,0, 2'b11,1,32'h00000077,32'h3000, 2'b00,0,0,0,
                  1,32'h3000,32'h00000077, 0,0,0,
                  1,1,4'hF,32'h00000077, 0,0,0,0, 3'b100};
      tbl[10] = '{0,0, 2'b10,0,32'h00000005,32'h50, 2'b00,0,0,0,
                  1,32'h54,32'h00000005, 0,0,0,
                  0,0,0,0, 0,0,0,0, 3'b101};
      tbl[11] = '{0,1, 2'b10,0,32'hFFFF1234,32'h60, 2'b10,0,32'h00001234,32'h60,
                  1,32'h60,32'h00001234, 1,32'h60,32'hABCD1234,
                  0,0,0,0, 0,0,0,0, 3'b000};

      // Reset state
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      drive(tbl[0]);
      #12;
      chk("rst_in_ready", 0, 32'(in_ready), 32'd1);
      chk("rst_reg_we", 0, 32'(reg_we), 32'd0);
      chk("rst_wdata", 0, reg_wdata, 32'd0);
      chk("rst_wsel_mask", 0, {25'd0, reg_wsel, reg_wmask}, 32'd0);
      chk("rst_out_valid", 0, 32'(out_valid), 32'd0);
      chk("rst_fault", 0, {28'd0, fault, fault_code}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Table vectors
      for (int i = 0; i < 12; i++) begin
         run(tbl[i]);
         verify(tbl[i], i);
      end

      // Handshake: result held while out_ready=0, new bundles ignored.
      @(negedge clk);
      drive(tbl[6]);
      in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      for (int c = 0; c < 8 && !out_valid; c++) @(negedge clk);
      chk("hs_reach_done", 100, 32'(out_valid), 32'd1);
      for (int c = 0; c < 5; c++) begin
         chk("hs_out_valid", 100 + c, 32'(out_valid), 32'd1);
         chk("hs_fault", 100 + c, {28'd0, fault, fault_code}, 32'h0000000C);
         chk("hs_in_ready", 100 + c, 32'(in_ready), 32'd0);
         chk("hs_reg_we", 100 + c, 32'(reg_we), 32'd0);
         drive(tbl[0]);
         in_valid = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      chk("hs_release_in_ready", 105, 32'(in_ready), 32'd1);
      chk("hs_release_out_valid", 105, 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("hs_no_ghost_write", 105, 32'(reg_we), 32'd0);

      // Reset during D0: write stops at once, no D1 write follows.
      @(negedge clk);
      drive(tbl[2]);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("rm_d0_we", 200, 32'(reg_we), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("rm_we_async", 200, 32'(reg_we), 32'd0);
      chk("rm_in_ready_async", 200, 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         chk("rm_idle_we", 201 + c, 32'(reg_we), 32'd0);
         chk("rm_idle_ov", 201 + c, 32'(out_valid), 32'd0);
         chk("rm_idle_ready", 201 + c, 32'(in_ready), 32'd1);
         @(negedge clk);
      end

      // Randomized bundles against the model
      for (int i = 0; i < 300; i++) begin
         v.r1b = 1'($urandom_range(0, 1));
         v.p16 = 1'($urandom_range(0, 1));
         v.k0  = 2'($urandom_range(0, 3));
         v.k1  = 2'($urandom_range(0, 3));
         v.s0  = $urandom; v.s1 = $urandom;
         v.r0  = $urandom; v.r1 = $urandom;
         v.a0  = 32'h100 + 32'(4 * $urandom_range(0, 1));
         v.a1  = 32'h100 + 32'(4 * $urandom_range(0, 1));
         v.h1w = 1'($urandom_range(0, 1));
         v.h2w = 1'($urandom_range(0, 1));
         v.h1a = 32'h100 + 32'(4 * $urandom_range(0, 2));
         v.h2a = 32'h100 + 32'(4 * $urandom_range(0, 2));
         case ($urandom_range(0, 2))
            0: v.h1d = v.r0;
            1: v.h1d = v.r1;
            default: v.h1d = $urandom;
         endcase
         case ($urandom_range(0, 2))
            0: v.h2d = v.r0;
            1: v.h2d = v.r1;
            default: v.h2d = $urandom;
         endcase
         if ($urandom_range(0, 3) == 0) v.h1d = v.h1d ^ 32'hFF00_0000;
         if ($urandom_range(0, 3) == 0) v.h2d = v.h2d ^ 32'h00FF_0000;
         v = model(v);
         run(v);
         verify(v, 1000 + i);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
